// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared constants for the instruction-fetch controller:
//   - fetch FSM state encoding
//   - default reset / exception-handler PCs
//   - legal instruction-fetch window used by the optional address check
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

  // Inclusive bounds of the instruction memory window.
  localparam logic [31:0] FETCH_LO = 32'h0000_3000;
  localparam logic [31:0] FETCH_HI = 32'h0000_6FFF;

  // True when a fetch from addr would raise an address error:
  // misaligned word, or outside the instruction window.
  function automatic logic fetch_addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < FETCH_LO) || (addr > FETCH_HI);
  endfunction

endpackage

// File: rtl/fetch_ctrl_adel_chk.sv
// ---------------------------------------------------------------------------
// fetch_adel_chk
// Combinational fetch address-error detector.
// Ports:
//   addr_i  32  address about to be fetched
//   adel_o   1  high when addr_i is misaligned or outside the fetch window
// ---------------------------------------------------------------------------
module fetch_adel_chk
  import fetch_ctrl_pkg::*;
(
  input  logic [31:0] addr_i,
  output logic        adel_o
);

  assign adel_o = fetch_addr_bad(addr_i);

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch controller. Issues one instruction-memory request at a
// time, holds the fetched instruction for the pipeline while it stalls, and
// redirects to the exception handler or an eret target.
//
// Optional build macro: FETCH_ADEL_CHECK_EN
//   Defined   : misaligned / out-of-window PCs are not requested; the FSM
//               goes straight to HOLD with instr=0 and fetch_adel=1.
//   Undefined : fetch_adel is tied 0 and every PC is requested.
//
// Ports:
//   clk          in   1  clock, rising edge
//   reset        in   1  asynchronous active-high reset
//   stall        in   1  pipeline cannot accept the held instruction
//   npc          in  32  next PC from the next-PC unit
//   exc_req      in   1  exception taken (overrides stall)
//   eret_req     in   1  eret retired, return to epc
//   epc          in  32  return address from CP0
//   im_req       out  1  instruction-memory request
//   im_addr      out 32  request address (equals pc)
//   im_gnt       in   1  memory accepts the request this cycle
//   im_rvalid    in   1  read data valid
//   im_rdata     in  32  read data
//   pc           out 32  address of the current / held instruction
//   instr        out 32  fetched instruction
//   instr_valid  out  1  instr is valid for pc
//   fetch_adel   out  1  address error on fetch, valid with instr_valid
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | one cycle after reset before the first request
// REQ    | im_req high for pc, waiting for im_gnt
// WAIT   | request granted, waiting for im_rvalid (or draining it)
// HOLD   | instr valid for pc, waiting for the pipeline to take it
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_adel
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         adel_q, adel_d;
  logic         drop_q, drop_d;
  logic         adel_w;
  logic         req_w;

`ifdef FETCH_ADEL_CHECK_EN
  fetch_adel_chk u_adel_chk (
    .addr_i (pc_q),
    .adel_o (adel_w)
  );
`else
  assign adel_w = 1'b0;
`endif

  // A bad address never reaches memory.
  assign req_w = (state_q == S_REQ) && !adel_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    adel_d  = adel_q;
    drop_d  = drop_q;

    // An exception always retargets to the handler and invalidates the
    // held instruction; the per-state code only decides where to go.
    if (exc_req) begin
      pc_d    = EXC_PC;
      valid_d = 1'b0;
      adel_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (exc_req) begin
          // Not yet granted: simply re-issue for the handler address.
          // Granted in the same cycle: the old read is in flight, so drain it.
          if (req_w && im_gnt) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end else if (adel_w) begin
          state_d = S_HOLD;
          instr_d = '0;
          valid_d = 1'b1;
          adel_d  = 1'b1;
        end else if (im_gnt) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (im_rvalid) begin
          if (drop_q || exc_req) begin
            // Stale response for an abandoned PC; pc_q already holds the
            // handler address, so just go request it.
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = im_rdata;
            valid_d = 1'b1;
            adel_d  = 1'b0;
            state_d = S_HOLD;
          end
        end else if (exc_req) begin
          // Response still outstanding: stay here so only one request is
          // ever in flight, and discard it when it arrives.
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (exc_req) begin
          state_d = S_REQ;
        end else if (!stall) begin
          pc_d    = eret_req ? epc : npc;
          valid_d = 1'b0;
          adel_d  = 1'b0;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign im_req      = req_w;
  assign im_addr     = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_adel  = adel_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] npc;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_adel;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc         (npc),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_gnt      (im_gnt),
    .im_rvalid   (im_rvalid),
    .im_rdata    (im_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_adel  (fetch_adel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard when the DUT presents a valid instruction.
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'b0, (exp_q.size() > 0)}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_instr"}, instr, e.instr);
      chk({tag, "_adel"}, {31'b0, fetch_adel}, {31'b0, e.adel});
    end
  endtask

  // Called with the DUT in REQ: same-cycle grant, read data one cycle later.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    chk({tag, "_req"}, {31'b0, im_req}, 32'd1);
    chk({tag, "_addr"}, im_addr, addr);
    im_gnt = 1'b1;
    tick();
    im_gnt    = 1'b0;
    im_rvalid = 1'b1;
    im_rdata  = data;
    e.pc = addr; e.instr = data; e.adel = 1'b0;
    exp_q.push_back(e);
    tick();
    im_rvalid = 1'b0;
    im_rdata  = '0;
    check_out(tag);
  endtask

  initial begin
    reset     = 1'b1;
    stall     = 1'b0;
    npc       = '0;
    exc_req   = 1'b0;
    eret_req  = 1'b0;
    epc       = '0;
    im_gnt    = 1'b0;
    im_rvalid = 1'b0;
    im_rdata  = '0;

    tick();
    tick();
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, im_req}, 32'd0);
    chk("rst_adel", {31'b0, fetch_adel}, 32'd0);

    // First fetch after reset release: valid at cycle 3.
    reset = 1'b0;
    cyc   = 0;
    tick();
    serve("first", 32'h0000_3000, 32'h2008_0001);
    chk("first_latency", cyc, 32'd3);

    // Stall holds everything for 4 cycles.
    stall = 1'b1;
    npc   = 32'h0000_3004;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_pc", pc, 32'h0000_3000);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_req", {31'b0, im_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_valid", {31'b0, instr_valid}, 32'd0);
    serve("npc", 32'h0000_3004, 32'h2409_0004);

    // Exception while waiting: in-flight data must be discarded.
    npc = 32'h0000_3008;
    tick();
    chk("w_req", {31'b0, im_req}, 32'd1);
    chk("w_addr", im_addr, 32'h0000_3008);
    im_gnt = 1'b1;
    tick();
    im_gnt  = 1'b0;
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    chk("drop_valid0", {31'b0, instr_valid}, 32'd0);
    chk("drop_req0", {31'b0, im_req}, 32'd0);
    chk("drop_pc", pc, 32'h0000_4180);
    im_rvalid = 1'b1;
    im_rdata  = 32'hDEAD_3008;
    tick();
    im_rvalid = 1'b0;
    im_rdata  = '0;
    chk("drop_valid1", {31'b0, instr_valid}, 32'd0);
    chk("drop_instr", {31'b0, (instr == 32'hDEAD_3008)}, 32'd0);
    serve("exc_wait", 32'h0000_4180, 32'h1111_4180);

    // Exception in REQ before grant: retarget, no drop.
    npc = 32'h0000_3030;
    tick();
    chk("rq_addr", im_addr, 32'h0000_3030);
    exc_req = 1'b1;
    tick();
    exc_req = 1'b0;
    chk("rq_valid", {31'b0, instr_valid}, 32'd0);
    serve("exc_req", 32'h0000_4180, 32'h2222_4180);

    // eret takes epc over npc.
    eret_req = 1'b1;
    epc      = 32'h0000_3010;
    npc      = 32'h0000_3004;
    tick();
    eret_req = 1'b0;
    serve("eret", 32'h0000_3010, 32'h3333_3010);

    // exc_req beats eret_req and npc.
    exc_req  = 1'b1;
    eret_req = 1'b1;
    tick();
    exc_req  = 1'b0;
    eret_req = 1'b0;
    serve("prio", 32'h0000_4180, 32'h4444_4180);

    // Misaligned next PC.
    npc = 32'h0000_3002;
    tick();
`ifdef FETCH_ADEL_CHECK_EN
    begin
      exp_t e;
      chk("adel_noreq", {31'b0, im_req}, 32'd0);
      e.pc = 32'h0000_3002; e.instr = 32'h0; e.adel = 1'b1;
      exp_q.push_back(e);
      tick();
      check_out("adel");
    end
`else
    serve("noadel", 32'h0000_3002, 32'h5555_3002);
`endif

    // Reset in the middle of WAIT, then stray read data.
    npc = 32'h0000_3020;
    tick();
    chk("rw_addr", im_addr, 32'h0000_3020);
    im_gnt = 1'b1;
    tick();
    im_gnt = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rw_pc", pc, 32'h0000_3000);
    chk("rw_valid", {31'b0, instr_valid}, 32'd0);
    chk("rw_req", {31'b0, im_req}, 32'd0);
    tick();
    reset     = 1'b0;
    im_rvalid = 1'b1;
    im_rdata  = 32'hBAD0_3020;
    tick();
    chk("stray_valid0", {31'b0, instr_valid}, 32'd0);
    chk("stray_addr", im_addr, 32'h0000_3000);
    tick();
    im_rvalid = 1'b0;
    im_rdata  = '0;
    chk("stray_valid1", {31'b0, instr_valid}, 32'd0);
    serve("after_rst", 32'h0000_3000, 32'h6666_3000);

    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
